// File: rtl/mult_hilo_unit.sv
// mult_hilo_unit: iterative signed multiplier with architectural HI/LO.
// The unit forms the product of the operand magnitudes with a shift-add
// datapath, one partial-product step per clock, and then fixes the sign.
// The result lands in HI/LO. A stall request holds the control FSM while
// a product is pending.

module mult_hilo_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mflo_req,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic [WIDTH-1:0] lo_out,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] mflo_data,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  // The step counter needs enough bits to reach WIDTH-1.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  // Controller states.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_SIGN = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]         state;
  logic [1:0]         state_next;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic               neg;
  logic [CW-1:0]      counter;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   hi_reg;
  logic [WIDTH-1:0]   lo_reg;
  logic               done_reg;

  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH:0]     addend;
  logic [WIDTH:0]     upper_sum;
  logic [2*WIDTH-1:0] acc_step;
  logic [2*WIDTH-1:0] acc_neg;
  logic               accept;

  // A start is honoured only from IDLE. While busy, the controller ignores
  // start, and the operands are not resampled.
  assign accept = (state == S_IDLE) && start;

  // Operand magnitudes. The most negative value maps onto itself. It is
  // read back as an unsigned number, which is exactly its magnitude.
  always_comb begin
    abs_a = srcA;
    abs_b = srcB;
    if (srcA[WIDTH-1]) abs_a = ~srcA + WIDTH'(1);
    if (srcB[WIDTH-1]) abs_b = ~srcB + WIDTH'(1);
  end

  // One shift-add step. The multiplicand is conditionally added to the
  // upper half of the accumulator, with one extra bit for the carry. The
  // {carry, acc} value is then shifted right by one.
  always_comb begin
    addend    = mplier[0] ? {1'b0, mcand} : '0;
    upper_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + addend;
    acc_step  = {upper_sum, acc[WIDTH-1:1]};
    acc_neg   = ~acc + (2*WIDTH)'(1);
  end

  // Next-state logic for the controller.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (start) state_next = S_CALC;
      S_CALC: if (counter == LAST_STEP) state_next = S_SIGN;
      S_SIGN: state_next = S_DONE;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // State register. A reset mid-operation drops back to IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  // Operand registers: load the magnitudes and the result sign on start.
  // The multiplier then shifts one bit per step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcand  <= '0;
      mplier <= '0;
      neg    <= 1'b0;
    end else if (accept) begin
      mcand  <= abs_a;
      mplier <= abs_b;
      neg    <= srcA[WIDTH-1] ^ srcB[WIDTH-1];
    end else if (state == S_CALC) begin
      mplier <= mplier >> 1;
    end
  end

  // Step counter. It restarts on start and advances once per step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                counter <= '0;
    else if (accept)           counter <= '0;
    else if (state == S_CALC)  counter <= counter + CW'(1);
  end

  // Accumulator. It is cleared on start and advanced in CALC. In SIGN it
  // is negated as a whole 2*WIDTH value when the operand signs differ.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                     acc <= '0;
    else if (accept)                acc <= '0;
    else if (state == S_CALC)       acc <= acc_step;
    else if (state == S_SIGN && neg) acc <= acc_neg;
  end

  // HI/LO change only when a finished product is committed, or on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_reg <= '0;
      lo_reg <= '0;
    end else if (state == S_DONE) begin
      hi_reg <= acc[2*WIDTH-1:WIDTH];
      lo_reg <= acc[WIDTH-1:0];
    end
  end

  // Done pulse: high for the single cycle after HI/LO are loaded.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) done_reg <= 1'b0;
    else        done_reg <= (state == S_DONE);
  end

  // The done cycle is already back in IDLE, so busy is low there. In that
  // cycle a held mflo is released, and it sees the new LO.
  assign busy      = (state != S_IDLE);
  assign stall     = busy && (mflo_req || start);
  assign hi_out    = hi_reg;
  assign lo_out    = lo_reg;
  assign mflo_data = lo_reg;
  assign done      = done_reg;

endmodule

// File: tb/tb_mult_hilo_unit.sv
// tb_mult_hilo_unit: scoreboard bench for mult_hilo_unit.
// The driver pushes the full signed product onto a queue when it issues a
// multiply. A monitor pops and compares the queue whenever done is seen.

module tb_mult_hilo_unit;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             mflo_req = 1'b0;
  logic [WIDTH-1:0] srcA = '0;
  logic [WIDTH-1:0] srcB = '0;
  logic [WIDTH-1:0] lo_out;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] mflo_data;
  logic             busy;
  logic             done;
  logic             stall;

  int check_count = 0;
  int pass_count  = 0;

  logic [63:0] exp_q[$];
  logic [63:0] mon_exp;
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  mult_hilo_unit #(.WIDTH(WIDTH)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .mflo_req(mflo_req),
    .srcA(srcA),
    .srcB(srcB),
    .lo_out(lo_out),
    .hi_out(hi_out),
    .mflo_data(mflo_data),
    .busy(busy),
    .done(done),
    .stall(stall)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Reference: plain signed 64-bit multiplication of the two operands.
  function automatic logic [63:0] ref_product(input logic [31:0] a, input logic [31:0] b);
    longint pa;
    longint pb;
    pa = longint'(signed'(a));
    pb = longint'(signed'(b));
    return 64'(pa * pb);
  endfunction

  // Compare one value and record the outcome.
  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Monitor: every done pulse must match the oldest outstanding product.
  always @(negedge clk) begin
    if (reset && done) begin
      if (exp_q.size() == 0) begin
        check_output("unexpected_done", 64'd1, 64'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check_output("hi", 64'(hi_out), 64'(mon_exp[63:32]));
        check_output("lo", 64'(lo_out), 64'(mon_exp[31:0]));
      end
    end
  end

  // Issue one start pulse. Optionally raise mflo_req in the same IDLE cycle.
  task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b,
                                input bit with_mflo, input bit expect_result);
    @(posedge clk);
    #1;
    start    = 1'b1;
    srcA     = a;
    srcB     = b;
    mflo_req = with_mflo;
    @(negedge clk);
    if (with_mflo) begin
      check_output("idle_mflo_stall", 64'(stall), 64'd0);
      check_output("idle_mflo_old_lo", 64'(mflo_data), 64'(model_lo));
    end
    if (expect_result) exp_q.push_back(ref_product(a, b));
    @(posedge clk);
    #1;
    start    = 1'b0;
    mflo_req = 1'b0;
    srcA     = $urandom;
    srcB     = $urandom;
  endtask

  // Wait for done, with a bound. Busy and stall cycles are counted on the way.
  task automatic wait_done(output int busy_cycles, output int stall_cycles);
    bit seen;
    seen = 1'b0;
    busy_cycles = 0;
    stall_cycles = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy)  busy_cycles++;
      if (stall) stall_cycles++;
    end
    if (!seen) begin
      check_output("done_timeout", 64'd0, 64'd1);
      exp_q.delete();
    end
  endtask

  // Commit the model's view of HI/LO. Then confirm that the registers hold.
  task automatic commit_and_hold(input logic [63:0] p);
    model_hi = p[63:32];
    model_lo = p[31:0];
    repeat (3) @(negedge clk);
    check_output("hold_hi", 64'(hi_out), 64'(model_hi));
    check_output("hold_lo", 64'(lo_out), 64'(model_lo));
  endtask

  initial begin
    int bc;
    int sc;
    int done_seen;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] pats [6];

    // Reset and check the idle state.
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    check_output("rst_busy", 64'(busy), 64'd0);
    check_output("rst_done", 64'(done), 64'd0);
    check_output("rst_hi", 64'(hi_out), 64'd0);
    check_output("rst_lo", 64'(lo_out), 64'd0);
    reset = 1'b1;
    mflo_req = 1'b1;
    @(negedge clk);
    check_output("idle_no_stall", 64'(stall), 64'd0);
    mflo_req = 1'b0;

    // 3*5: busy is high for 34 cycles and low in the done cycle.
    apply_stimulus(32'd3, 32'd5, 1'b0, 1'b1);
    wait_done(bc, sc);
    check_output("busy_cycles", 64'(bc), 64'd34);
    check_output("busy_in_done", 64'(busy), 64'd0);
    commit_and_hold(ref_product(32'd3, 32'd5));

    // Directed sign and boundary cases.
    apply_stimulus(32'hFFFF_FFFE, 32'd3, 1'b1, 1'b1);
    wait_done(bc, sc);
    commit_and_hold(ref_product(32'hFFFF_FFFE, 32'd3));
    apply_stimulus(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1);
    wait_done(bc, sc);
    check_output("min_sq_hi", 64'(hi_out), 64'h4000_0000);
    commit_and_hold(ref_product(32'h8000_0000, 32'h8000_0000));
    apply_stimulus(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 1'b1);
    wait_done(bc, sc);
    commit_and_hold(ref_product(32'h7FFF_FFFF, 32'h7FFF_FFFF));

    // 7*6 with mflo pending from cycle 2. It is stalled until the done cycle.
    apply_stimulus(32'd7, 32'd6, 1'b0, 1'b1);
    @(posedge clk);
    #1 mflo_req = 1'b1;
    wait_done(bc, sc);
    check_output("mflo_stall_cycles", 64'(sc), 64'd33);
    check_output("mflo_done_stall", 64'(stall), 64'd0);
    check_output("mflo_data", 64'(mflo_data), 64'h2A);
    mflo_req = 1'b0;
    commit_and_hold(ref_product(32'd7, 32'd6));

    // 9*9, with a stray start at cycle 5 and reset at cycle 10. The run is aborted.
    apply_stimulus(32'd9, 32'd9, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1;
    srcA  = 32'd1;
    srcB  = 32'd1;
    @(negedge clk);
    check_output("busy_start_stall", 64'(stall), 64'd1);
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check_output("abort_busy", 64'(busy), 64'd0);
    check_output("abort_hi", 64'(hi_out), 64'd0);
    check_output("abort_lo", 64'(lo_out), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_hi = '0;
    model_lo = '0;
    done_seen = 0;
    repeat (50) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check_output("abort_no_done", 64'(done_seen), 64'd0);
    apply_stimulus(32'd9, 32'd9, 1'b0, 1'b1);
    wait_done(bc, sc);
    check_output("restart_lo", 64'(lo_out), 64'h51);
    commit_and_hold(ref_product(32'd9, 32'd9));

    // Randomised operands, biased toward the sign and magnitude extremes.
    pats[0] = 32'h8000_0000;
    pats[1] = 32'h7FFF_FFFF;
    pats[2] = 32'hFFFF_FFFF;
    pats[3] = 32'h0000_0000;
    pats[4] = 32'h0000_0001;
    pats[5] = 32'hFFFF_0000;
    for (int n = 0; n < 24; n++) begin
      ra = ($urandom_range(0, 2) == 0) ? pats[$urandom_range(0, 5)] : $urandom;
      rb = ($urandom_range(0, 2) == 0) ? pats[$urandom_range(0, 5)] : $urandom;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      apply_stimulus(ra, rb, 1'($urandom_range(0, 1)), 1'b1);
      wait_done(bc, sc);
      check_output("rand_busy_cycles", 64'(bc), 64'd34);
      commit_and_hold(ref_product(ra, rb));
    end

    check_output("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
